// File: rtl/ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// ps2_kbd_rx
//
// PS/2 keyboard receiver. It takes the raw PS/2 pins, deframes 11-bit frames
// (start, 8 data LSB first, odd parity, stop), folds the E0/F0 prefix bytes
// into flags and queues fully decoded key events in a first-word-fall-through
// FIFO for the system-clock consumer.
//
// Parameters
//   DEPTH_LOG2   FIFO depth = 2**DEPTH_LOG2 entries (1..6)
//   TIMEOUT_CYC  clk cycles without a ps2_clk fall mid-frame before abandoning
//
// Ports
//   clk          system clock, all logic on posedge
//   clrk         synchronous active-high reset
//   ps2_clk      PS/2 clock pin (asynchronous)
//   ps2_data     PS/2 data pin (asynchronous)
//   nextdate_n   active-low pop request, level sensitive, one entry per cycle
//   code         scan code of the FIFO head (0 when empty)
//   is_break     head entry is a release (F0-prefixed)
//   is_ext       head entry is extended (E0-prefixed)
//   ready        FIFO non-empty
//   count        FIFO occupancy, 0..2**DEPTH_LOG2
//   overflow     sticky: a push was dropped because the FIFO was full
//   frame_err    one-cycle pulse on a parity/stop error or a frame timeout
//
// Build option
//   PS2_TYPEMATIC_FILTER_EN  when defined, repeated make events of the key
//                            that was last pushed are suppressed until its
//                            break event arrives (auto-repeat filter).
// -----------------------------------------------------------------------------
module ps2_kbd_rx #(
   parameter int unsigned DEPTH_LOG2  = 3,
   parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
   input  logic                  clk,
   input  logic                  clrk,
   input  logic                  ps2_clk,
   input  logic                  ps2_data,
   input  logic                  nextdate_n,
   output logic [7:0]            code,
   output logic                  is_break,
   output logic                  is_ext,
   output logic                  ready,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  overflow,
   output logic                  frame_err
);

   localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

   // Occupancy value meaning "full"; count is one bit wider than the pointers
   // so it can represent DEPTH itself.
   localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

   localparam logic [7:0] PREFIX_EXT = 8'hE0;
   localparam logic [7:0] PREFIX_BRK = 8'hF0;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   // --------------------------------------------------------------------------
   // Pin synchronisers and falling-edge detect
   // --------------------------------------------------------------------------
   logic [2:0] clk_sync;
   logic [1:0] data_sync;
   logic       fall;
   logic       rx_bit;

   // NOTE: every clocked register is written with <= so that all flops update
   // together from the values present before the edge; a blocking = here
   // would let later statements see already-shifted values.
   always_ff @(posedge clk) begin
      if (clrk) begin
         clk_sync  <= 3'b111;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   // Data passes through the same two flops as clk_sync[1], so the sampled
   // bit is aligned with the edge that selects it.
   assign fall   = clk_sync[2] & ~clk_sync[1];
   assign rx_bit = data_sync[1];

   // --------------------------------------------------------------------------
   // Frame FSM and watchdog
   // --------------------------------------------------------------------------
   logic [1:0]  state;
   logic [2:0]  bit_idx;
   logic [7:0]  shreg;
   logic        par_bit;
   logic [15:0] wd_cnt;
   logic        byte_vld;
   logic        timeout;

   assign timeout = (state != ST_IDLE) && (wd_cnt == TIMEOUT_CYC);

   always_ff @(posedge clk) begin
      if (clrk) begin
         state     <= ST_IDLE;
         bit_idx   <= '0;
         shreg     <= '0;
         par_bit   <= 1'b0;
         wd_cnt    <= '0;
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         byte_vld  <= 1'b0;
         frame_err <= 1'b0;

         if (fall || (state == ST_IDLE))
            wd_cnt <= '0;
         else
            wd_cnt <= wd_cnt + 16'd1;

         if (timeout) begin
            // Stalled frame: drop whatever was collected and report it.
            state     <= ST_IDLE;
            wd_cnt    <= '0;
            frame_err <= 1'b1;
         end else if (fall) begin
            case (state)
               ST_IDLE: begin
                  // A high start bit is line noise, not an error.
                  if (!rx_bit) begin
                     state   <= ST_DATA;
                     bit_idx <= '0;
                  end
               end
               ST_DATA: begin
                  // LSB arrives first: shift right, new bit enters at the top.
                  shreg   <= {rx_bit, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7)
                     state <= ST_PARITY;
               end
               ST_PARITY: begin
                  par_bit <= rx_bit;
                  state   <= ST_STOP;
               end
               ST_STOP: begin
                  if ((^{shreg, par_bit}) && rx_bit)
                     byte_vld <= 1'b1;
                  else
                     frame_err <= 1'b1;
                  state <= ST_IDLE;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   // --------------------------------------------------------------------------
   // Prefix decoder
   // --------------------------------------------------------------------------
   logic       ext_pend;
   logic       brk_pend;
   logic       is_prefix;
   logic       ev_valid;
   logic [9:0] ev_entry;
   logic       push_req;
   logic       push_acc;
   logic       do_pop;
   logic       full;

   assign is_prefix = (shreg == PREFIX_EXT) || (shreg == PREFIX_BRK);
   assign ev_valid  = byte_vld && !is_prefix;
   assign ev_entry  = {ext_pend, brk_pend, shreg};

   always_ff @(posedge clk) begin
      if (clrk) begin
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (frame_err) begin
         // A corrupted frame may have been the real key byte; stale prefixes
         // must not attach themselves to the next good byte.
         ext_pend <= 1'b0;
         brk_pend <= 1'b0;
      end else if (byte_vld) begin
         if (shreg == PREFIX_EXT) begin
            ext_pend <= 1'b1;
         end else if (shreg == PREFIX_BRK) begin
            brk_pend <= 1'b1;
         end else begin
            ext_pend <= 1'b0;
            brk_pend <= 1'b0;
         end
      end
   end

`ifdef PS2_TYPEMATIC_FILTER_EN
   // --------------------------------------------------------------------------
   // Typematic filter: remember the last make that entered the FIFO and drop
   // identical makes until that key's break event arrives.
   // --------------------------------------------------------------------------
   logic [8:0] last_make;
   logic       last_vld;
   logic       repeat_hit;

   assign repeat_hit = last_vld && (last_make == {ext_pend, shreg});
   assign push_req   = ev_valid && !(!brk_pend && repeat_hit);

   always_ff @(posedge clk) begin
      if (clrk) begin
         last_make <= '0;
         last_vld  <= 1'b0;
      end else if (ev_valid) begin
         if (brk_pend) begin
            if (repeat_hit)
               last_vld <= 1'b0;
         end else if (push_acc) begin
            last_make <= {ext_pend, shreg};
            last_vld  <= 1'b1;
         end
      end
   end
`else
   assign push_req = ev_valid;
`endif

   // --------------------------------------------------------------------------
   // First-word-fall-through FIFO
   // --------------------------------------------------------------------------
   logic [9:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wptr;
   logic [DEPTH_LOG2-1:0] rptr;
   logic [9:0]            head;

   assign ready  = (count != '0);
   assign full   = (count == FULL_CNT);
   assign do_pop = !nextdate_n && ready;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_acc = push_req && (!full || do_pop);

   // NOTE: the storage array has no reset; only the pointers and count do.
   // Entries are never observed until written, and leaving the array out of
   // reset lets it map onto plain RAM/LUT storage.
   always_ff @(posedge clk) begin
      if (push_acc)
         mem[wptr] <= ev_entry;
   end

   always_ff @(posedge clk) begin
      if (clrk) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_acc)
            wptr <= wptr + 1'b1;
         if (do_pop)
            rptr <= rptr + 1'b1;

         case ({push_acc, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase

         if (push_req && full && !do_pop)
            overflow <= 1'b1;
      end
   end

   // Head is forced to zero while empty so the outputs read 0 out of reset.
   assign head = ready ? mem[rptr] : 10'd0;
   assign {is_ext, is_break, code} = head;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// -----------------------------------------------------------------------------
// tb_ps2_kbd_rx
//
// Drives PS/2 frames bit by bit into ps2_kbd_rx (DEPTH_LOG2=2, short timeout)
// and compares the FIFO outputs against a queue-based model of the key-event
// rules: prefix bytes set flags, other bytes become entries, errors clear the
// flags, a full FIFO drops and sets the sticky overflow.
// -----------------------------------------------------------------------------
module tb_ps2_kbd_rx;

   localparam int DLOG  = 2;
   localparam int DEPTH = 1 << DLOG;
   localparam int TMO   = 300;
   localparam int HALF  = 8;
   localparam int GAP   = 6;

   logic            clk;
   logic            clrk;
   logic            ps2_clk;
   logic            ps2_data;
   logic            nextdate_n;
   logic [7:0]      code;
   logic            is_break;
   logic            is_ext;
   logic            ready;
   logic [DLOG:0]   count;
   logic            overflow;
   logic            frame_err;

   ps2_kbd_rx #(
      .DEPTH_LOG2  (DLOG),
      .TIMEOUT_CYC (16'(TMO))
   ) dut (
      .clk        (clk),
      .clrk       (clrk),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .nextdate_n (nextdate_n),
      .code       (code),
      .is_break   (is_break),
      .is_ext     (is_ext),
      .ready      (ready),
      .count      (count),
      .overflow   (overflow),
      .frame_err  (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;
   int ferr_cnt = 0;

   always @(negedge clk) begin
      if (frame_err === 1'b1)
         ferr_cnt++;
   end

   // ---------------------------------------------------------------- model
   logic [9:0] mq [$];
   logic       m_ext;
   logic       m_brk;
   logic       m_ovf;
   logic [8:0] f_key;
   logic       f_vld;

   function automatic void model_clear();
      mq.delete();
      m_ext = 1'b0;
      m_brk = 1'b0;
      m_ovf = 1'b0;
      f_key = '0;
      f_vld = 1'b0;
   endfunction

   function automatic void model_err();
      m_ext = 1'b0;
      m_brk = 1'b0;
   endfunction

   function automatic void model_byte(input logic [7:0] b);
      logic keep;
      if (b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (b == 8'hF0) begin
         m_brk = 1'b1;
      end else begin
         keep = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
         if (f_vld && f_key == {m_ext, b}) begin
            if (m_brk) f_vld = 1'b0;
            else       keep  = 1'b0;
         end
`endif
         if (keep) begin
            if (mq.size() < DEPTH) begin
               mq.push_back({m_ext, m_brk, b});
`ifdef PS2_TYPEMATIC_FILTER_EN
               if (!m_brk) begin
                  f_key = {m_ext, b};
                  f_vld = 1'b1;
               end
`endif
            end else begin
               m_ovf = 1'b1;
            end
         end
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endfunction

   // ---------------------------------------------------------------- checks
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_state(input string name);
      check({name, " count"}, 32'(count), 32'(mq.size()));
      check({name, " ready"}, 32'(ready), 32'(mq.size() != 0));
      check({name, " overflow"}, 32'(overflow), 32'(m_ovf));
      if (mq.size() != 0)
         check({name, " head"}, 32'({is_ext, is_break, code}), 32'(mq[0]));
   endtask

   // ---------------------------------------------------------------- stimulus
   task automatic ps2_bit(input logic v);
      ps2_data = v;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
   endtask

   // mode 0: good frame, 1: bad parity, 2: bad stop,
   // 3: good frame with E+1/E+2 visibility check, 4: good frame with a pop
   //    timed to land in the same cycle as the push.
   task automatic send_byte(input logic [7:0] b, input int mode);
      logic par;
      par = ~^b;
      if (mode == 1) par = ~par;
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(b[i]);
      ps2_bit(par);
      if (mode == 3 || mode == 4) begin
         ps2_data = 1'b1;
         repeat (HALF) @(negedge clk);
         ps2_clk = 1'b0;
         repeat (3) @(negedge clk);
         if (mode == 3) check("latency E+1 count", 32'(count), 32'(mq.size()));
         if (mode == 4) nextdate_n = 1'b0;
         @(negedge clk);
         if (mode == 3) check("latency E+2 count", 32'(count), 32'(mq.size() + 1));
         nextdate_n = 1'b1;
         repeat (HALF - 4) @(negedge clk);
         ps2_clk = 1'b1;
      end else begin
         ps2_bit(mode == 2 ? 1'b0 : 1'b1);
      end
      ps2_data = 1'b1;
      repeat (GAP) @(negedge clk);
      if (mode == 1 || mode == 2) begin
         model_err();
      end else begin
         if (mode == 4) void'(mq.pop_front());
         model_byte(b);
      end
   endtask

   task automatic send_partial(input int nbits);
      ps2_bit(1'b0);
      for (int i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)));
      ps2_data = 1'b1;
   endtask

   task automatic pop_one();
      nextdate_n = 1'b0;
      @(negedge clk);
      nextdate_n = 1'b1;
      if (mq.size() != 0) void'(mq.pop_front());
      @(negedge clk);
   endtask

   task automatic pop_hold(input int k);
      nextdate_n = 1'b0;
      repeat (k) @(negedge clk);
      nextdate_n = 1'b1;
      for (int i = 0; i < k; i++)
         if (mq.size() != 0) void'(mq.pop_front());
      @(negedge clk);
   endtask

   task automatic reset_dut();
      clrk = 1'b1;
      @(negedge clk);
      clrk = 1'b0;
      model_clear();
      @(negedge clk);
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct {
      logic [0:2][7:0] b;
      int              n;
      logic [9:0]      exp;
   } vec_t;

   vec_t       vecs [6];
   logic [7:0] pool [6];
   int         f0;
   int         r;
   logic [7:0] rb;

   initial begin
      vecs[0] = '{'{8'h1C, 8'h00, 8'h00}, 1, {1'b0, 1'b0, 8'h1C}};
      vecs[1] = '{'{8'hF0, 8'h1C, 8'h00}, 2, {1'b0, 1'b1, 8'h1C}};
      vecs[2] = '{'{8'hE0, 8'h75, 8'h00}, 2, {1'b1, 1'b0, 8'h75}};
      vecs[3] = '{'{8'hE0, 8'hF0, 8'h75}, 3, {1'b1, 1'b1, 8'h75}};
      vecs[4] = '{'{8'hF0, 8'hE0, 8'h6B}, 3, {1'b1, 1'b1, 8'h6B}};
      vecs[5] = '{'{8'hE0, 8'hE0, 8'h12}, 3, {1'b1, 1'b0, 8'h12}};
      pool = '{8'h1C, 8'h32, 8'h75, 8'h6B, 8'h5A, 8'h29};

      clrk       = 1'b1;
      ps2_clk    = 1'b1;
      ps2_data   = 1'b1;
      nextdate_n = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
      clrk = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst code", 32'(code), 32'h0);
      check("rst is_break", 32'(is_break), 32'h0);
      check("rst is_ext", 32'(is_ext), 32'h0);
      check("rst ready", 32'(ready), 32'h0);
      check("rst count", 32'(count), 32'h0);
      check("rst overflow", 32'(overflow), 32'h0);
      check("rst frame_err", 32'(frame_err), 32'h0);

      // Table-driven prefix decoding: each vector yields exactly one entry
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < vecs[i].n; j++) send_byte(vecs[i].b[j], 0);
         check($sformatf("vec%0d count", i), 32'(count), 32'd1);
         check($sformatf("vec%0d head", i), 32'({is_ext, is_break, code}), 32'(vecs[i].exp));
         pop_one();
         check($sformatf("vec%0d drained", i), 32'(count), 32'd0);
      end

      // Make then break: two entries, F0 never stored
      send_byte(8'h1C, 0);
      send_byte(8'hF0, 0);
      send_byte(8'h1C, 0);
      check("mk/brk count", 32'(count), 32'd2);
      check("mk/brk head0", 32'({is_ext, is_break, code}), 32'({1'b0, 1'b0, 8'h1C}));
      pop_one();
      check("mk/brk head1", 32'({is_ext, is_break, code}), 32'({1'b0, 1'b1, 8'h1C}));
      pop_one();
      check("mk/brk empty", 32'(ready), 32'd0);

      // Push visibility two cycles after the stop-bit edge
      send_byte(8'h5A, 3);
      check_state("latency");
      pop_one();

      // Bad parity: one error pulse, nothing stored, next frame fine
      f0 = ferr_cnt;
      send_byte(8'h1C, 1);
      check("parity err pulses", 32'(ferr_cnt - f0), 32'd1);
      check_state("parity no push");
      send_byte(8'h1C, 0);
      check_state("after parity");
      pop_one();

      // Bad stop bit
      f0 = ferr_cnt;
      send_byte(8'h29, 2);
      check("stop err pulses", 32'(ferr_cnt - f0), 32'd1);
      check_state("stop no push");

      // An error between prefix and key drops the prefix
      send_byte(8'hE0, 0);
      send_byte(8'h75, 1);
      send_byte(8'h75, 0);
      check("pend cleared head", 32'({is_ext, is_break, code}), 32'({1'b0, 1'b0, 8'h75}));
      pop_one();

      // Watchdog: stall after 4 data bits
      f0 = ferr_cnt;
      send_partial(4);
      repeat (TMO - 50) @(negedge clk);
      check("timeout not early", 32'(ferr_cnt - f0), 32'd0);
      repeat (150) @(negedge clk);
      check("timeout pulses", 32'(ferr_cnt - f0), 32'd1);
      model_err();
      send_byte(8'h32, 0);
      check("after timeout head", 32'({is_ext, is_break, code}), 32'({1'b0, 1'b0, 8'h32}));
      check_state("after timeout");
      pop_one();

      // Reset in the middle of a frame discards it
      send_partial(3);
      f0 = ferr_cnt;
      reset_dut();
      check_state("mid-frame reset");
      send_byte(8'h1C, 0);
      check("post-reset head", 32'({is_ext, is_break, code}), 32'({1'b0, 1'b0, 8'h1C}));
      check("post-reset no err", 32'(ferr_cnt - f0), 32'd0);
      pop_one();

      // Simultaneous push and pop while full
      reset_dut();
      send_byte(8'h16, 0);
      send_byte(8'h1E, 0);
      send_byte(8'h26, 0);
      send_byte(8'h25, 0);
      check("full count", 32'(count), 32'd4);
      send_byte(8'h2E, 4);
      check("push+pop count", 32'(count), 32'd4);
      check("push+pop no ovf", 32'(overflow), 32'd0);
      check("push+pop head", 32'({is_ext, is_break, code}), 32'({1'b0, 1'b0, 8'h1E}));
      for (int i = 0; i < 4; i++) begin
         check_state($sformatf("drain%0d", i));
         pop_one();
      end
      check_state("drained");

      // Overflow: five makes into four slots, then pop in order
      reset_dut();
      send_byte(8'h15, 0);
      send_byte(8'h1D, 0);
      send_byte(8'h24, 0);
      send_byte(8'h2D, 0);
      send_byte(8'h2C, 0);
      check("ovf count", 32'(count), 32'd4);
      check("ovf flag", 32'(overflow), 32'd1);
      check("ovf pop0", 32'(code), 32'h15);
      pop_one();
      check("ovf pop1", 32'(code), 32'h1D);
      pop_one();
      check("ovf pop2", 32'(code), 32'h24);
      pop_one();
      check("ovf pop3", 32'(code), 32'h2D);
      pop_one();
      check("ovf empty ready", 32'(ready), 32'd0);
      pop_one();
      check("pop empty ignored", 32'(count), 32'd0);
      check("ovf sticky", 32'(overflow), 32'd1);

      // Holding the pop request longer than the occupancy
      reset_dut();
      send_byte(8'h1C, 0);
      send_byte(8'h32, 0);
      send_byte(8'h5A, 0);
      pop_hold(6);
      check("hold pop count", 32'(count), 32'd0);
      check_state("hold pop");

`ifdef PS2_TYPEMATIC_FILTER_EN
      reset_dut();
      send_byte(8'h1C, 0);
      send_byte(8'h1C, 0);
      send_byte(8'h1C, 0);
      send_byte(8'hF0, 0);
      send_byte(8'h1C, 0);
      send_byte(8'h1C, 0);
      check("filter count", 32'(count), 32'd3);
      check("filter e0", 32'({is_ext, is_break, code}), 32'({1'b0, 1'b0, 8'h1C}));
      pop_one();
      check("filter e1", 32'({is_ext, is_break, code}), 32'({1'b0, 1'b1, 8'h1C}));
      pop_one();
      check("filter e2", 32'({is_ext, is_break, code}), 32'({1'b0, 1'b0, 8'h1C}));
      pop_one();
`endif

      // Randomized traffic against the model
      reset_dut();
      for (int it = 0; it < 60; it++) begin
         r = int'($urandom_range(0, 11));
         rb = pool[$urandom_range(0, 5)];
         if (r == 11) begin
            rb = 8'($urandom_range(1, 255));
            if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h11;
         end
         if (r < 2)       send_byte(8'hE0, 0);
         else if (r < 4)  send_byte(8'hF0, 0);
         else if (r == 4) send_byte(rb, 1);
         else if (r < 8)  pop_one();
         else             send_byte(rb, 0);
         check_state($sformatf("rand%0d", it));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
